hssim_del_fuse: RTL and testbench
=================================

# hssim_del_fuse

Consumer end of the HSSIM decision stream. Accepts the old/new edge-map beats entering the HSSIM pipeline, holds them in a delay line matched to the HSSIM advance-latency, and merges each returning `del` beat per pixel into a fused output map on a valid/ready stream. It is the only source of the HSSIM `stall` input, including the end-of-frame flush of bubble beats that drains the pipeline.

## Interface
Parameters:
- PIXELS_PER_BEAT, 16, pixels per beat, 8 bits each
- IMAGE_DIM, 512, frame is IMAGE_DIM x IMAGE_DIM pixels
- DATA_WIDTH, 8*PIXELS_PER_BEAT, beat width
- LATENCY, 8, number of non-stalled cycles from a beat entering HSSIM to its `del` appearing; must be >= 1
- BEATS_PER_FRAME, IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT, beats per frame

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- s_valid  in  1  upstream beat valid
- s_ready  out  1  upstream beat accepted when s_valid & s_ready
- old_map  in  DATA_WIDTH  old edge-map beat, also driven to HSSIM
- new_map  in  DATA_WIDTH  new edge-map beat, also driven to HSSIM
- stall  out  1  to HSSIM and its feature pipelines; pipeline advances when low
- del  in  DATA_WIDTH  HSSIM decision beat, 8'hFF or 8'h00 per pixel
- m_valid  out  1  fused beat valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_WIDTH  fused beat
- m_last  out  1  high on the final fused beat of a frame

## Operation
- out_space = !m_valid | m_ready.
- States: RUN (reset state), FLUSH.
- RUN: s_ready = out_space; advance = s_valid & out_space. BEATS_PER_FRAME accepted beats -> FLUSH (counter cleared).
- FLUSH: s_ready = 0; advance = out_space; HSSIM inputs carry the current (don't-care) bus values, tagged invalid. After exactly LATENCY advances -> RUN.
- stall = ~advance, combinational.
- Delay line: LATENCY entries of {vld, old, new}, shifting only on advance; head loads {state==RUN, old_map, new_map}.
- On advance with tail vld = 1: output register loads, per pixel i, m_data[i] = (del[i] == 8'hFF) ? tail.new[i] : tail.old[i]; m_valid set. Any del byte other than 8'hFF selects old.
- On advance with tail vld = 0: m_valid cleared if m_ready, else held.
- Without advance: m_valid cleared when m_ready, output held otherwise.
- Output beat counter counts m_valid & m_ready; m_last = (count == BEATS_PER_FRAME-1) & m_valid; wraps to 0 after the last beat.
- Bubble beats never produce output; each frame yields exactly BEATS_PER_FRAME output beats.

## Timing
- Reset: state RUN, all delay-line vld = 0, counters 0, m_valid = 0, m_data = 0, m_last = 0, s_ready = 1 then (out_space), stall = ~s_valid.
- Reset mid-frame: all in-flight beats discarded; no partial-frame output after reset deassertion.
- Latency: fused beat for input k is registered on the LATENCY-th advance after the advance that accepted k; m_valid high the next cycle.
- Throughput: one beat per cycle when s_valid and m_ready stay high.
- m_ready low with m_valid high: advance = 0, stall = 1, s_ready = 0; m_data/m_last stable.
- Last input beat and FLUSH entry: the cycle after the accepting advance, s_ready = 0.
- Back-to-back frames: frame N+1 input accepted in the cycle after the LATENCY-th flush advance.

## Configuration
- HSSIM_DEL_FUSE_CNT_EN defined: extra outputs sel_count (out, clog2(IMAGE_DIM*IMAGE_DIM)+1 bits) and sel_count_valid (out, 1). sel_count counts the pixels selected from new over all output beats of a frame; it is registered and sel_count_valid pulses for one cycle, both in the cycle after the m_last handshake; the accumulator then clears. Reset: both 0.
- Undefined: ports absent, no counter logic.

## Test plan
- LATENCY=3, IMAGE_DIM=8, PIXELS_PER_BEAT=16 (4 beats), del model = 3-stage pipe of (new>old?FF:00), continuous valid/ready -> first m_valid 4 cycles after first accept, 4 beats out, m_last on beat 3, each pixel = max-style select.
- del all 8'hFF vs all 8'h00 -> m_data equals new_map vs old_map exactly.
- m_ready low for 5 cycles mid-frame -> stall high those cycles, m_data stable, no beat lost or duplicated.
- s_valid gaps of 2 cycles between beats -> stall high during gaps, output identical to gapless run.
- Two frames back-to-back -> s_ready low exactly 3 advance cycles between them, m_last twice, 8 beats total.
- Reset asserted after 2 accepted beats -> no output for them; next frame produces 4 correct beats; with HSSIM_DEL_FUSE_CNT_EN, del pattern 5 FF pixels per beat -> sel_count = 20.

Source files
------------

// File: rtl/hssim_del_fuse.sv
// hssim_del_fuse: merges HSSIM del beats into a fused edge map and drives stall.
// Optional HSSIM_DEL_FUSE_CNT_EN adds a per-frame count of pixels taken from new.
module hssim_del_fuse #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_DIM       = 512,
  parameter int DATA_WIDTH      = 8*PIXELS_PER_BEAT,
  parameter int LATENCY         = 8,
  parameter int BEATS_PER_FRAME = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] old_map,
  input  logic [DATA_WIDTH-1:0] new_map,
  output logic                  stall,
  input  logic [DATA_WIDTH-1:0] del,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
`ifdef HSSIM_DEL_FUSE_CNT_EN
  ,
  output logic [$clog2(IMAGE_DIM*IMAGE_DIM):0] sel_count,
  output logic                                 sel_count_valid
`endif
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;
  localparam int FW = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [0:0]            state;
  logic [FW-1:0]         in_cnt;
  logic [FW-1:0]         out_cnt;
  logic [LW-1:0]         fl_cnt;
  logic                  out_space;
  logic                  advance;
  logic                  dl_vld [LATENCY];
  logic [DATA_WIDTH-1:0] dl_old [LATENCY];
  logic [DATA_WIDTH-1:0] dl_new [LATENCY];
  logic [DATA_WIDTH-1:0] fused;

  assign out_space = !m_valid || m_ready;
  assign advance   = (state == RUN) ? (s_valid && out_space) : out_space;
  assign s_ready   = (state == RUN) && out_space;
  assign stall     = !advance;
  assign m_last    = m_valid && (out_cnt == FW'(BEATS_PER_FRAME-1));

  always_comb begin
    fused = '0;
    for (int i = 0; i < PIXELS_PER_BEAT; i++) begin
      fused[8*i +: 8] = (del[8*i +: 8] == 8'hFF) ?
        dl_new[LATENCY-1][8*i +: 8] : dl_old[LATENCY-1][8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      in_cnt <= '0;
      fl_cnt <= '0;
    end else if (advance) begin
      case (state)
        RUN: begin
          if (in_cnt == FW'(BEATS_PER_FRAME-1)) begin
            state  <= FLUSH;
            in_cnt <= '0;
          end else begin
            in_cnt <= in_cnt + 1'b1;
          end
        end
        default: begin
          if (fl_cnt == LW'(LATENCY-1)) begin
            state  <= RUN;
            fl_cnt <= '0;
          end else begin
            fl_cnt <= fl_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Bubbles enter during FLUSH so the tail of the last real beat meets its del.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) dl_vld[i] <= 1'b0;
    end else if (advance) begin
      dl_vld[0] <= (state == RUN);
      for (int i = 1; i < LATENCY; i++) dl_vld[i] <= dl_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      dl_old[0] <= old_map;
      dl_new[0] <= new_map;
      for (int i = 1; i < LATENCY; i++) begin
        dl_old[i] <= dl_old[i-1];
        dl_new[i] <= dl_new[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (advance && dl_vld[LATENCY-1]) begin
      m_valid <= 1'b1;
      m_data  <= fused;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_cnt <= '0;
    end else if (m_valid && m_ready) begin
      out_cnt <= m_last ? '0 : out_cnt + 1'b1;
    end
  end

`ifdef HSSIM_DEL_FUSE_CNT_EN
  localparam int SW = $clog2(IMAGE_DIM*IMAGE_DIM) + 1;
  localparam int PW = $clog2(PIXELS_PER_BEAT+1);

  logic [PW-1:0] beat_sel;
  logic [PW-1:0] beat_sel_q;
  logic [SW-1:0] sel_acc;

  always_comb begin
    beat_sel = '0;
    for (int i = 0; i < PIXELS_PER_BEAT; i++) begin
      if (del[8*i +: 8] == 8'hFF) beat_sel = beat_sel + 1'b1;
    end
  end

  // Per-beat count rides with m_data so it is summed at the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_sel_q      <= '0;
      sel_acc         <= '0;
      sel_count       <= '0;
      sel_count_valid <= 1'b0;
    end else begin
      sel_count_valid <= 1'b0;
      if (advance && dl_vld[LATENCY-1]) beat_sel_q <= beat_sel;
      if (m_valid && m_ready) begin
        if (m_last) begin
          sel_count       <= sel_acc + SW'(beat_sel_q);
          sel_count_valid <= 1'b1;
          sel_acc         <= '0;
        end else begin
          sel_acc <= sel_acc + SW'(beat_sel_q);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_hssim_del_fuse.sv
// tb_hssim_del_fuse: random-stimulus bench with a del pipe model and scoreboard.
// Define HSSIM_DEL_FUSE_CNT_EN to also check the selected-pixel count.
module tb_hssim_del_fuse;

  localparam int PPB = 16;
  localparam int DIM = 8;
  localparam int LAT = 3;
  localparam int DW  = 8*PPB;
  localparam int BPF = DIM*DIM/PPB;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] old_map;
  logic [DW-1:0] new_map;
  logic          stall;
  logic [DW-1:0] del;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [DW-1:0] del_in;
`ifdef HSSIM_DEL_FUSE_CNT_EN
  logic [$clog2(DIM*DIM):0] sel_count;
  logic                     sel_count_valid;
`endif

  always #5 clk = ~clk;

  hssim_del_fuse #(
    .PIXELS_PER_BEAT(PPB),
    .IMAGE_DIM(DIM),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .old_map(old_map),
    .new_map(new_map),
    .stall(stall),
    .del(del),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_last(m_last)
`ifdef HSSIM_DEL_FUSE_CNT_EN
    ,
    .sel_count(sel_count),
    .sel_count_valid(sel_count_valid)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // HSSIM stand-in: del for a beat appears after LAT non-stalled cycles.
  logic [DW-1:0] dpipe [LAT];
  initial for (int i = 0; i < LAT; i++) dpipe[i] = '0;
  always @(posedge clk) begin
    if (!stall) begin
      dpipe[0] <= del_in;
      for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
    end
  end
  assign del = dpipe[LAT-1];

  function automatic logic [DW-1:0] fuse(input logic [DW-1:0] o,
      input logic [DW-1:0] n, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = o;
    for (int i = 0; i < PPB; i++)
      if (d[8*i +: 8] == 8'hFF) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic int npop(input logic [DW-1:0] d);
    int c = 0;
    for (int i = 0; i < PPB; i++) if (d[8*i +: 8] == 8'hFF) c++;
    return c;
  endfunction

  function automatic logic [DW-1:0] gen_del(input int mode,
      input logic [DW-1:0] o, input logic [DW-1:0] n);
    logic [DW-1:0] d;
    int r;
    d = '0;
    for (int i = 0; i < PPB; i++) begin
      case (mode)
        0: d[8*i +: 8] = (n[8*i +: 8] > o[8*i +: 8]) ? 8'hFF : 8'h00;
        1: d[8*i +: 8] = 8'hFF;
        2: d[8*i +: 8] = 8'h00;
        4: d[8*i +: 8] = (i < 5) ? 8'hFF : 8'h00;
        default: begin
          r = $urandom_range(0, 2);
          d[8*i +: 8] = (r == 0) ? 8'hFF : (r == 1) ? 8'h00 : 8'($urandom);
        end
      endcase
    end
    return d;
  endfunction

  logic [DW-1:0] exp_q [$];
  int            sel_q [$];
  int            acc_cyc [$];
  int            cyc = 0;
  int            out_idx = 0;
  int            out_total = 0;
  int            last_total = 0;
  int            exp_frames = 0;
  int            rdy_low = 0;
  bit            rdy_rand = 0;
  bit            arm_next = 0;
  bit            lat_arm = 0;
  int            lat_acc = 0;
  bit            prev_hold = 0;
  logic [DW-1:0] prev_data = '0;
  int            sel_acc = 0;
  int            exp_sel = 0;
  int            sel_seen = 0;
  int            sel_last = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rdy_low > 0) begin
      m_ready = 1'b0;
      rdy_low--;
    end else if (rdy_rand) begin
      m_ready = ($urandom_range(0, 3) != 0);
    end else begin
      m_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 0;
    end else begin
`ifdef HSSIM_DEL_FUSE_CNT_EN
      if (sel_count_valid) begin
        chk("sel_count", DW'(sel_count), DW'(exp_sel));
        sel_seen++;
        sel_last = int'(sel_count);
      end
`endif
      if (lat_arm && m_valid) begin
        chk("latency", DW'(cyc - lat_acc), DW'(LAT + 1));
        lat_arm = 0;
      end
      if (prev_hold) begin
        chk("hold_data", m_data, prev_data);
        chk("hold_valid", DW'(m_valid), DW'(1));
      end
      if (m_valid && !m_ready) begin
        chk("hold_stall", DW'(stall), DW'(1));
        chk("hold_sready", DW'(s_ready), DW'(0));
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", DW'(exp_q.size()), DW'(1));
        end else begin
          int s;
          chk("m_data", m_data, exp_q.pop_front());
          s = sel_q.pop_front();
          chk("m_last", DW'(m_last), DW'(out_idx == BPF-1));
          out_total++;
          if (m_last) last_total++;
          if (out_idx == BPF-1) begin
            exp_sel = sel_acc + s;
            sel_acc = 0;
            out_idx = 0;
          end else begin
            sel_acc += s;
            out_idx++;
          end
        end
      end
    end
  end

  task automatic send_beat(input int mode, input int gap);
    int n = 0;
    logic [DW-1:0] o, nw;
    for (int i = 0; i < DW/32; i++) begin
      o[32*i +: 32]  = $urandom;
      nw[32*i +: 32] = $urandom;
    end
    old_map = o;
    new_map = nw;
    del_in  = gen_del(mode, o, nw);
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!s_ready) begin
      chk("accept_timeout", DW'(s_ready), DW'(1));
    end else begin
      exp_q.push_back(fuse(o, nw, del_in));
      sel_q.push_back(npop(del_in));
      acc_cyc.push_back(cyc);
      if (arm_next) begin
        lat_acc  = cyc;
        lat_arm  = 1;
        arm_next = 0;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    del_in  = gen_del(3, o, nw);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      chk("gap_stall", DW'(stall), DW'(1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int mode, input int gap, input bit rgap);
    for (int b = 0; b < BPF; b++)
      send_beat(mode, (b == BPF-1) ? 0 : (rgap ? $urandom_range(0, 2) : gap));
    exp_frames++;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", DW'(exp_q.size()), DW'(0));
    repeat (LAT + 2) @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    int n;
    reset   = 1'b1;
    s_valid = 1'b0;
    old_map = '0;
    new_map = '0;
    del_in  = '0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_m_valid", DW'(m_valid), DW'(0));
    chk("rst_m_data", m_data, DW'(0));
    chk("rst_m_last", DW'(m_last), DW'(0));
    chk("rst_s_ready", DW'(s_ready), DW'(1));
    chk("rst_stall_lo", DW'(stall), DW'(1));
    s_valid = 1'b1;
    #1;
    chk("rst_stall_hi", DW'(stall), DW'(0));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    reset   = 1'b0;
    @(posedge clk);
    #1;

    acc_cyc.delete();
    arm_next = 1;
    send_frame(0, 0, 0);
    drain();
    chk("thru_1", DW'(acc_cyc[1] - acc_cyc[0]), DW'(1));
    chk("thru_3", DW'(acc_cyc[3] - acc_cyc[2]), DW'(1));

    send_frame(1, 0, 0);
    drain();
    send_frame(2, 0, 0);
    drain();

    fork
      send_frame(0, 0, 0);
      begin
        n = 0;
        while (!m_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        rdy_low = 5;
      end
    join
    drain();

    send_frame(0, 2, 0);
    drain();

    acc_cyc.delete();
    send_frame(0, 0, 0);
    send_frame(0, 0, 0);
    drain();
    chk("b2b_gap", DW'(acc_cyc[BPF] - acc_cyc[BPF-1]), DW'(LAT + 1));
    chk("b2b_thru", DW'(acc_cyc[BPF+1] - acc_cyc[BPF]), DW'(1));

    t0 = out_total;
    send_beat(0, 0);
    send_beat(0, 0);
    reset = 1'b1;
    exp_q.delete();
    sel_q.delete();
    out_idx = 0;
    sel_acc = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    send_frame(0, 0, 0);
    drain();
    chk("post_rst_beats", DW'(out_total - t0), DW'(BPF));

    rdy_rand = 1;
    for (int f = 0; f < 3; f++) send_frame(3, 0, 1);
    drain();
    rdy_rand = 0;

`ifdef HSSIM_DEL_FUSE_CNT_EN
    t0 = sel_seen;
    send_frame(4, 0, 0);
    drain();
    chk("sel_pulse", DW'(sel_seen - t0), DW'(1));
    chk("sel_20", DW'(sel_last), DW'(20));
`endif

    chk("frames_last", DW'(last_total), DW'(exp_frames));
    chk("beats_total", DW'(out_total), DW'(exp_frames*BPF));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
